axi_config_wr_burst: RTL
========================

# axi_config_wr_burst

Parametrised AXI4 write slave that converts AXI write bursts into a flow-controlled register-write port for configuration register files. It extends the basic config write adapter in four ways: FIXED/INCR/WRAP burst decode, size-aware address stepping, backpressure from the register side, and error responses. It sits between an AXI interconnect master port and a register bank. The bank sees one write per accepted data beat, in beat order.

## Interface
Parameters:
- ADDR_WIDTH, 32: AXI and register address width in bits.
- DATA_WIDTH, 32: data width in bits; must be 8·STRB_WIDTH.
- STRB_WIDTH, DATA_WIDTH/8: byte-lane count.
- ID_WIDTH, 8: AXI ID width.
- REG_SPACE_BYTES, 4096: decoded space. A beat whose address is >= this value is not forwarded and forces DECERR.
- BUSER_ENABLE, 0: drive s_axi_buser; when 0, s_axi_buser is tied to 0.
- BUSER_WIDTH, 1: buser width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  AW payload.
- s_axi_awvalid  in  1; s_axi_awready  out  1.
- s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/STRB_WIDTH/1  W payload.
- s_axi_wvalid  in  1; s_axi_wready  out  1.
- s_axi_bid/bresp/buser  out  ID_WIDTH/2/BUSER_WIDTH  B payload.
- s_axi_bvalid  out  1; s_axi_bready  in  1.
- wr_valid  out  1: register write request.
- wr_ready  in  1: the bank accepts the request.
- wr_addr/wr_data/wr_strb  out  ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH: write payload, stable while wr_valid && !wr_ready.
- wr_err  in  1: bank error, sampled on the wr_valid && wr_ready cycle.

## Operation
- States: IDLE, DATA, RESP.
- IDLE:
  - s_axi_awready = 1.
  - On an AW handshake, capture id, addr, len, size and burst; clear the beat counter and error flags; go to DATA.
- AW legality check, done at capture. A burst is illegal if any of these hold:
  - awburst = 2'b11;
  - awsize > log2(STRB_WIDTH);
  - WRAP with awlen not in {1,3,7,15}.
  An illegal burst still consumes all of its W beats but issues no register writes, and returns SLVERR.
- DATA:
  - s_axi_wready = !wr_valid || wr_ready. This is combinational through wr_ready and forms a one-entry output register.
  - Each W handshake loads the output register with the current beat address plus wdata/wstrb. wr_valid is set only if the burst is legal and the address is < REG_SPACE_BYTES; otherwise the DECERR flag is set.
- Address step per beat, with step = 1<<size:
  - FIXED: address unchanged.
  - INCR: next = (addr & ~(step-1)) + step.
  - WRAP: mask = ((len+1)<<size)-1; next = (addr & ~mask) | ((addr+step) & mask).
- Burst end:
  - The burst ends on the beat where the counter equals awlen; then go to RESP.
  - If wlast disagrees with the counter on any beat, set the SLVERR flag. Termination still follows awlen.
- Any wr handshake with wr_err = 1 sets the SLVERR flag.
- RESP:
  - Wait until wr_valid = 0, i.e. the last write has drained. Then assert s_axi_bvalid with bid = captured id and buser = 0.
  - bresp priority: DECERR (2'b11) > SLVERR (2'b10) > OKAY (2'b00).
  - Hold bvalid and payload until s_axi_bready; then go to IDLE.
- Only one burst is in flight. AW is not accepted outside IDLE.

## Timing
- Reset values:
  - state = IDLE.
  - awready, wready, bvalid, wr_valid = 0.
  - bid, bresp, buser, wr_addr, wr_data, wr_strb = 0.
  - awready is forced 0 while rst is high and rises the cycle after rst falls.
- Reset mid-burst aborts the burst: wr_valid drops and no B response is issued.
- AW handshake at cycle T: awready = 0 at T+1, and wready can be 1 at T+1.
- W handshake at N: wr_valid = 1 at N+1.
- With wr_ready held at 1:
  - full-rate transfer, one beat per cycle;
  - last beat at N gives bvalid at N+2.
- wr_ready = 0 with wr_valid = 1: wready = 0 in the same cycle. No beat is lost or duplicated.
- B handshake at K: awready = 1 at K+1.
- An AW presented while bvalid is pending is held off until the B handshake completes.

## Test plan
- INCR, awaddr = 0x100, len = 3, size = 2, wr_ready = 1 -> four writes to 0x100/0x104/0x108/0x10C with matching data and strb; bresp = OKAY, bid echoed; bvalid at last-beat + 2.
- WRAP, awaddr = 0x38, len = 3, size = 2 -> writes to 0x38, 0x3C, 0x30, 0x34; FIXED, awaddr = 0x20, len = 2 -> three writes to 0x20.
- Backpressure: wr_ready toggles 1010… during an 8-beat INCR -> wready tracks !wr_valid || wr_ready; exactly 8 writes, in order, no duplicates; bvalid only after the final write is accepted.
- Out of range: INCR at 0xFFC, len = 1, REG_SPACE_BYTES = 4096 -> one write to 0xFFC; beat at 0x1000 suppressed; bresp = DECERR.
- Errors:
  - wr_err = 1 on the second beat -> SLVERR.
  - awburst = 3 with len = 1 -> both W beats accepted, zero writes, SLVERR.
  - wlast asserted early on beat 0 of a len = 1 burst -> 2 writes, SLVERR.
- Reset asserted mid-burst after beat 1 of 4 -> all outputs return to their reset values the next cycle; awready = 1 one cycle after rst falls; a new burst then completes with OKAY.

Source files
------------

// File: rtl/axi_config_wr_burst_if.sv
// AXI4 write-channel bundle (AW/W/B) for the burst config write adapter.
// The slave modport is the adapter side; master is the interconnect side.
interface axi_config_wr_burst_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int BUSER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]    s_axi_awid;
    logic [ADDR_WIDTH-1:0]  s_axi_awaddr;
    logic [7:0]             s_axi_awlen;
    logic [2:0]             s_axi_awsize;
    logic [1:0]             s_axi_awburst;
    logic                   s_axi_awvalid;
    logic                   s_axi_awready;
    logic [DATA_WIDTH-1:0]  s_axi_wdata;
    logic [STRB_WIDTH-1:0]  s_axi_wstrb;
    logic                   s_axi_wlast;
    logic                   s_axi_wvalid;
    logic                   s_axi_wready;
    logic [ID_WIDTH-1:0]    s_axi_bid;
    logic [1:0]             s_axi_bresp;
    logic [BUSER_WIDTH-1:0] s_axi_buser;
    logic                   s_axi_bvalid;
    logic                   s_axi_bready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen,
        input  s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_buser, s_axi_bvalid,
        input  s_axi_bready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen,
        output s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_buser, s_axi_bvalid,
        output s_axi_bready
    );
endinterface

// File: rtl/axi_config_wr_burst.sv
// AXI4 write slave turning FIXED/INCR/WRAP bursts into a flow-controlled
// register-write port, one write per data beat, with SLVERR/DECERR reporting.
module axi_config_wr_burst #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int REG_SPACE_BYTES = 4096,
    parameter int BUSER_ENABLE    = 0,
    parameter int BUSER_WIDTH     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_config_wr_burst_if.slave  axi,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_err
);

    localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0] SPACE = (ADDR_WIDTH + 1)'(REG_SPACE_BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  illegal_q;
    logic                  slverr_q;
    logic                  decerr_q;

    logic                  awready_q;
    logic                  bvalid_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [1:0]            bresp_q;

    logic                  wr_valid_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [STRB_WIDTH-1:0] wr_strb_q;

    logic                  wready;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  wr_hs;
    logic                  b_hs;
    logic                  last_beat;
    logic                  drained;
    logic                  in_range;
    logic                  aw_illegal;
    logic                  wrap_len_ok;

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] wrap_addr;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign aw_hs     = axi.s_axi_awvalid && awready_q;
    assign w_hs      = axi.s_axi_wvalid && wready;
    assign wr_hs     = wr_valid_q && wr_ready;
    assign b_hs      = bvalid_q && axi.s_axi_bready;
    assign last_beat = (cnt_q == len_q);
    assign drained   = !wr_valid_q || wr_ready;
    assign in_range  = ({1'b0, addr_q} < SPACE);

    assign wrap_len_ok = (axi.s_axi_awlen == 8'd1) ||
                         (axi.s_axi_awlen == 8'd3) ||
                         (axi.s_axi_awlen == 8'd7) ||
                         (axi.s_axi_awlen == 8'd15);

    assign aw_illegal = (axi.s_axi_awburst == 2'b11) ||
                        (axi.s_axi_awsize > SIZE_MAX) ||
                        ((axi.s_axi_awburst == 2'b10) && !wrap_len_ok);

    assign step      = ONE << size_q;
    assign incr_addr = (addr_q & ~(step - ONE)) + step;
    assign wrap_mask = ((ADDR_WIDTH'(len_q) + ONE) << size_q) - ONE;
    assign wrap_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);

    always_comb begin
        next_addr = addr_q;
        case (burst_q)
            2'b01:   next_addr = incr_addr;
            2'b10:   next_addr = wrap_addr;
            default: next_addr = addr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // Output register refills in the same cycle it drains.
                wready = !wr_valid_q || wr_ready;
                if (axi.s_axi_wvalid && wready && last_beat) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awready_q  <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            illegal_q  <= 1'b0;
            slverr_q   <= 1'b0;
            decerr_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
        end else begin
            awready_q <= (state_d == IDLE);

            if (aw_hs) begin
                id_q      <= axi.s_axi_awid;
                addr_q    <= axi.s_axi_awaddr;
                len_q     <= axi.s_axi_awlen;
                size_q    <= axi.s_axi_awsize;
                burst_q   <= axi.s_axi_awburst;
                cnt_q     <= '0;
                illegal_q <= aw_illegal;
                slverr_q  <= 1'b0;
                decerr_q  <= 1'b0;
            end

            if (w_hs) begin
                wr_addr_q  <= addr_q;
                wr_data_q  <= axi.s_axi_wdata;
                wr_strb_q  <= axi.s_axi_wstrb;
                wr_valid_q <= !illegal_q && in_range;
                addr_q     <= next_addr;
                cnt_q      <= cnt_q + 8'd1;
                if (!illegal_q && !in_range) begin
                    decerr_q <= 1'b1;
                end
                if (axi.s_axi_wlast != last_beat) begin
                    slverr_q <= 1'b1;
                end
            end else if (wr_ready) begin
                wr_valid_q <= 1'b0;
            end

            if (wr_hs && wr_err) begin
                slverr_q <= 1'b1;
            end

            // The final bank error is folded in on the draining handshake.
            if (state_q == RESP && !bvalid_q && drained) begin
                bvalid_q <= 1'b1;
                bid_q    <= id_q;
                if (decerr_q) begin
                    bresp_q <= RESP_DECERR;
                end else if (slverr_q || illegal_q || (wr_hs && wr_err)) begin
                    bresp_q <= RESP_SLVERR;
                end else begin
                    bresp_q <= RESP_OKAY;
                end
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // No user sideband source exists, so buser reads zero either way.
    if (BUSER_ENABLE != 0) begin : g_buser
        assign axi.s_axi_buser = {BUSER_WIDTH{1'b0}};
    end else begin : g_buser_tie
        assign axi.s_axi_buser = '0;
    end

    assign axi.s_axi_awready = awready_q;
    assign axi.s_axi_wready  = wready;
    assign axi.s_axi_bvalid  = bvalid_q;
    assign axi.s_axi_bid     = bid_q;
    assign axi.s_axi_bresp   = bresp_q;

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_strb  = wr_strb_q;

endmodule
